uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver: configurable data width, oversampling ratio and parity mode; second stop bit; 3-sample majority voting; false-start rejection; break detection.
Received frames are buffered, with per-frame error tags, in a first-word-fall-through FIFO.
Sits behind the shared baud generator's rx_clk_en tick and feeds the host/register side through a pop handshake.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
OVERSAMPLE, 16, rx_clk_en ticks per bit, even, legal 8..32
FIFO_DEPTH, 4, frame entries, power of two, legal 2..16

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
rx  in  1  serial input, asynchronous to clk
rx_clk_en  in  1  oversample tick, one clk wide
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
two_stop  in  1  1 = two stop bits expected
rd_en  in  1  pop head entry
state_clear  in  1  clear sticky flags
rd_data  out  DATA_BITS  head entry data (FWFT)
rd_perr  out  1  head entry parity error tag
rd_ferr  out  1  head entry framing error tag
empty  out  1  FIFO empty
count  out  $clog2(FIFO_DEPTH+1)  entries held
overrun  out  1  sticky: frame dropped because FIFO full
break_det  out  1  sticky: break condition seen

Behaviour:
- Reset (rst=0, async): FSM IDLE; counters 0; synchroniser flops 1; FIFO empty.
- Reset values: empty=1, count=0, rd_data/rd_perr/rd_ferr=0, overrun=0, break_det=0.
- Reset mid-frame: partial frame is discarded.
- rx passes a 2-flop synchroniser (reset value 1) before any use.
- FSM advances only on rx_clk_en. States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Sampling: in every state except IDLE, the sample counter runs 0..OVERSAMPLE-1 per bit.
  - Samples are taken at counts OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
  - Bit value is the majority of the 3 samples, resolved at count OVERSAMPLE/2+1.
- IDLE: on a tick with synchronised rx=0, go to START with counter=1.
- START: majority 1 = false start, return to IDLE with no push and no flag. Otherwise go to DATA at count OVERSAMPLE-1.
- DATA: bits captured LSB first. After DATA_BITS bits, go to PARITY if parity_mode is 01/10, else go to STOP1.
- Parity check:
  - Even mode: error when XOR(data, parity bit) = 1.
  - Odd mode: error when XOR(data, parity bit) = 0.
  - parity_mode is sampled at the START-to-DATA transition and held for the whole frame.
- STOP1: majority 0 sets the frame's ferr tag.
  - If two_stop=1 (also sampled at START), go to STOP2 at count OVERSAMPLE-1. STOP2 is checked the same way.
  - Final stop bit: the FSM enters IDLE immediately at the resolving tick (half-bit early, for resync), and the frame is pushed.
- Break: data=0, parity bit (if present)=0, and first stop bit=0.
  - Sets break_det; the frame is NOT pushed.
  - FSM waits in IDLE-hold until synchronised rx=1 before accepting a new start.
- Push timing:
  - Entry {perr, ferr, data} is written on the clk edge of the resolving tick. empty falls and count increments one clk later.
  - FWFT: rd_data is valid whenever empty=0.
- Pop: rd_en with empty=1 is ignored; the pointer is not moved.
- FIFO full at push: frame dropped, overrun set, contents unchanged.
- Push and pop in the same clk:
  - When full: the pop frees a slot and the push is accepted, no overrun, count unchanged.
  - When empty: the push is accepted and the pop is ignored.
- Pointers wrap modulo FIFO_DEPTH. count is the full/empty discriminator.
- state_clear clears overrun and break_det. If a set event occurs in the same clk, set wins.
- rx_clk_en=0 freezes the FSM. The FIFO still responds to rd_en.

Test Plan:
- DATA_BITS=8, OVERSAMPLE=16, parity 01, one stop; send 0xA5 with parity 0 -> one entry: rd_data=0xA5, rd_perr=0, rd_ferr=0, count=1.
- Odd parity; send 0x03 with parity bit 0 -> rd_data=0x03, rd_perr=1. Send 0x55 with stop bit 0 -> rd_ferr=1.
- rx low for 5 ticks, then high -> false start: no push, FSM in IDLE, later 0x3C received correctly. A single-tick glitch at mid-bit does not change the sampled bit.
- FIFO_DEPTH=4: send 5 frames with no pop -> count=4, overrun=1, head is still frame 1. Push and pop coincide when full -> overrun stays 0, count=4.
- rx held low for 2 frame times -> break_det=1, no push. No new frame is accepted until rx returns high. state_clear -> break_det=0.
- DATA_BITS=7, two_stop=1, OVERSAMPLE=8; send 0x7F with second stop=0 -> rd_ferr=1. Assert rst mid-frame -> empty=1, count=0, next frame is received intact.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver: 3-sample majority, parity, 1/2 stop bits, break detect,
// and a first-word-fall-through frame FIFO with per-entry error tags.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic                   rx_clk_en,
  input  logic [1:0]             parity_mode,
  input  logic                   two_stop,
  input  logic                   rd_en,
  input  logic                   state_clear,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic                   rd_perr,
  output logic                   rd_ferr,
  output logic                   empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                   overrun,
  output logic                   break_det
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] S0 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] S1 = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] S2 = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] SL = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_e;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [1:0]             smp_q;
  logic                   rx_s1_q, rx_s2_q;
  logic                   hold_q;
  logic [DATA_BITS-1:0]   sh_q;
  logic [BW-1:0]          bits_q;
  logic                   pbit_q;
  logic [1:0]             pmode_q;
  logic                   two_q;
  logic                   ferr_q;
  logic                   brk_q;
  logic                   push_q;
  logic [DATA_BITS-1:0]   pd_q;
  logic                   pp_q, pf_q;

  logic maj, res, last, par_en, par_x, perr_w, brk_w;

  assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s2_q)
             | (smp_q[1] & rx_s2_q);
  assign res    = (cnt_q == S2);
  assign last   = (cnt_q == SL);
  assign par_en = pmode_q[0] ^ pmode_q[1];
  assign par_x  = (^sh_q) ^ pbit_q;
  // odd mode flips the sense of the even-parity check
  assign perr_w = par_en & (par_x ^ pmode_q[1]);
  assign brk_w  = (sh_q == '0) & ~(par_en & pbit_q) & ~maj;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      smp_q   <= '1;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      hold_q  <= 1'b0;
      sh_q    <= '0;
      bits_q  <= '0;
      pbit_q  <= 1'b0;
      pmode_q <= 2'b00;
      two_q   <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      push_q  <= 1'b0;
      pd_q    <= '0;
      pp_q    <= 1'b0;
      pf_q    <= 1'b0;
    end else begin
      push_q  <= 1'b0;
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      if (state_clear) brk_q <= 1'b0;
      if (rx_clk_en) begin
        if (state_q != IDLE) begin
          cnt_q <= last ? '0 : cnt_q + CW'(1);
          if (cnt_q == S0) smp_q[0] <= rx_s2_q;
          if (cnt_q == S1) smp_q[1] <= rx_s2_q;
        end
        unique case (state_q)
          IDLE: begin
            if (hold_q) begin
              hold_q <= ~rx_s2_q;
            end else if (!rx_s2_q) begin
              state_q <= START;
              cnt_q   <= CW'(1);
            end
          end
          START: begin
            if (res && maj) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (last) begin
              state_q <= DATA;
              pmode_q <= parity_mode;
              two_q   <= two_stop;
              bits_q  <= '0;
            end
          end
          DATA: begin
            if (res) begin
              sh_q   <= {maj, sh_q[DATA_BITS-1:1]};
              bits_q <= bits_q + BW'(1);
            end
            if (last && bits_q == BW'(DATA_BITS))
              state_q <= par_en ? PARITY : STOP1;
          end
          PARITY: begin
            if (res) pbit_q <= maj;
            if (last) state_q <= STOP1;
          end
          STOP1: begin
            if (res) begin
              if (brk_w) begin
                brk_q   <= 1'b1;
                hold_q  <= 1'b1;
                state_q <= IDLE;
                cnt_q   <= '0;
              end else begin
                ferr_q <= ~maj;
                if (!two_q) begin
                  push_q  <= 1'b1;
                  pd_q    <= sh_q;
                  pp_q    <= perr_w;
                  pf_q    <= ~maj;
                  state_q <= IDLE;
                  cnt_q   <= '0;
                end
              end
            end else if (last) begin
              state_q <= STOP2;
            end
          end
          STOP2: begin
            if (res) begin
              push_q  <= 1'b1;
              pd_q    <= sh_q;
              pp_q    <= perr_w;
              pf_q    <= ferr_q | ~maj;
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic [DATA_BITS+1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wp_q, rp_q;
  logic [NW-1:0]        n_q, n_d;
  logic                 ovr_q;
  logic                 full, emp, do_pop, do_push;

  assign full    = (n_q == NW'(FIFO_DEPTH));
  assign emp     = (n_q == '0);
  assign do_pop  = rd_en & ~emp;
  assign do_push = push_q & (~full | do_pop);

  always_comb begin
    n_d = n_q;
    if (do_push && !do_pop) n_d = n_q + NW'(1);
    if (do_pop && !do_push) n_d = n_q - NW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      n_q   <= '0;
      ovr_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      n_q <= n_d;
      if (do_push) begin
        mem_q[wp_q] <= {pp_q, pf_q, pd_q};
        wp_q        <= wp_q + PW'(1);
      end
      if (do_pop) rp_q <= rp_q + PW'(1);
      if (state_clear) ovr_q <= 1'b0;
      if (push_q && full && !do_pop) ovr_q <= 1'b1;
    end
  end

  assign {rd_perr, rd_ferr, rd_data} = mem_q[rp_q];
  assign empty     = emp;
  assign count     = n_q;
  assign overrun   = ovr_q;
  assign break_det = brk_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N/8E/8O at x16 and 7N2 at x8.
// Frame checks are table-driven; FIFO and break corners are hand sequences.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst, b_rst;
  logic       rx, b_rx;
  logic       rx_clk_en;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       rd_en, b_rd_en;
  logic       state_clear, b_state_clear;

  logic [7:0] rd_data;
  logic       rd_perr, rd_ferr, empty, overrun, break_det;
  logic [2:0] count;

  logic [6:0] b_rd_data;
  logic       b_rd_perr, b_rd_ferr, b_empty, b_overrun, b_break_det;
  logic [2:0] b_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_clk_en(rx_clk_en),
    .parity_mode(parity_mode), .two_stop(two_stop),
    .rd_en(rd_en), .state_clear(state_clear),
    .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr),
    .empty(empty), .count(count), .overrun(overrun),
    .break_det(break_det)
  );

  uart_rx_fifo #(.DATA_BITS(7), .OVERSAMPLE(8), .FIFO_DEPTH(4)) dut7 (
    .clk(clk), .rst(b_rst), .rx(b_rx), .rx_clk_en(rx_clk_en),
    .parity_mode(parity_mode), .two_stop(two_stop),
    .rd_en(b_rd_en), .state_clear(b_state_clear),
    .rd_data(b_rd_data), .rd_perr(b_rd_perr), .rd_ferr(b_rd_ferr),
    .empty(b_empty), .count(b_count), .overrun(b_overrun),
    .break_det(b_break_det)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    logic       pb;
    logic       stp;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit is_b, input logic v);
    if (is_b) b_rx = v;
    else rx = v;
  endtask

  task automatic send(input bit is_b, input logic [15:0] b,
                      input int n, input int g);
    int os;
    os = is_b ? 8 : 16;
    for (int i = 0; i < n; i++) begin
      drv(is_b, b[i]);
      if (i == g) begin
        idle(9);
        drv(is_b, ~b[i]);
        idle(1);
        drv(is_b, b[i]);
        idle(os - 10);
      end else begin
        idle(os);
      end
    end
    drv(is_b, 1'b1);
  endtask

  // g: index of data bit to glitch for one clock, -1 for none
  task automatic frame(input bit is_b, input logic [7:0] d,
                       input int db, input logic [1:0] pm,
                       input logic pb, input logic s1,
                       input logic s2, input bit two, input int g);
    logic [15:0] b;
    int n;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < db; i++) b[1+i] = d[i];
    n = 1 + db;
    if (pm == 2'b01 || pm == 2'b10) begin
      b[n] = pb;
      n++;
    end
    b[n] = s1;
    n++;
    if (two) begin
      b[n] = s2;
      n++;
    end
    send(is_b, b, n, (g < 0) ? -1 : g + 1);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; b_rst = 1'b0;
    rx = 1'b1; b_rx = 1'b1;
    rx_clk_en = 1'b1;
    parity_mode = 2'b00; two_stop = 1'b0;
    rd_en = 1'b0; b_rd_en = 1'b0;
    state_clear = 1'b0; b_state_clear = 1'b0;

    tv[0] = '{8'hA5, 2'b01, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tv[1] = '{8'h03, 2'b10, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0};
    tv[2] = '{8'h55, 2'b10, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1};
    tv[3] = '{8'h01, 2'b01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tv[4] = '{8'h80, 2'b00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    tv[5] = '{8'h00, 2'b11, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tv[6] = '{8'h00, 2'b01, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    tv[7] = '{8'h7E, 2'b10, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0};

    idle(3);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_perr", rd_perr, 0);
    chk("rst_ferr", rd_ferr, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_brk", break_det, 0);
    rst = 1'b1; b_rst = 1'b1;
    idle(4);
    chk("post_rst_empty", empty, 1);

    for (int k = 0; k < 8; k++) begin
      parity_mode = tv[k].pm;
      frame(0, tv[k].d, 8, tv[k].pm, tv[k].pb, tv[k].stp,
            1'b1, 0, -1);
      idle(32);
      chk($sformatf("v%0d_data", k), rd_data, tv[k].ed);
      chk($sformatf("v%0d_perr", k), rd_perr, tv[k].ep);
      chk($sformatf("v%0d_ferr", k), rd_ferr, tv[k].ef);
      chk($sformatf("v%0d_count", k), count, 1);
      pop();
      chk($sformatf("v%0d_popped", k), empty, 1);
    end
    parity_mode = 2'b00;

    // false start, then a frame with a one-clock mid-bit glitch
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(40);
    chk("false_start_empty", empty, 1);
    frame(0, 8'h3C, 8, 2'b00, 0, 1, 1, 0, 2);
    idle(32);
    chk("glitch_data", rd_data, 8'h3C);
    chk("glitch_ferr", rd_ferr, 0);
    chk("glitch_count", count, 1);
    pop();

    // overrun on the fifth frame
    for (int k = 1; k <= 5; k++) begin
      frame(0, 8'(k * 17), 8, 2'b00, 0, 1, 1, 0, -1);
      idle(32);
    end
    chk("full_count", count, 4);
    chk("full_ovr", overrun, 1);
    chk("full_head", rd_data, 8'h11);
    state_clear = 1'b1;
    idle(1);
    state_clear = 1'b0;
    chk("ovr_cleared", overrun, 0);

    // pop lands on the push clock while full
    fork
      frame(0, 8'h66, 8, 2'b00, 0, 1, 1, 0, -1);
      begin
        idle(156);
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
      end
    join
    idle(32);
    chk("coinc_full_ovr", overrun, 0);
    chk("coinc_full_cnt", count, 4);
    chk("coinc_full_head", rd_data, 8'h22);

    rx_clk_en = 1'b0;
    chk("drain0", rd_data, 8'h22); pop();
    chk("drain1", rd_data, 8'h33); pop();
    chk("drain2", rd_data, 8'h44); pop();
    chk("drain3", rd_data, 8'h66); pop();
    chk("drained", empty, 1);
    pop();
    chk("pop_empty_cnt", count, 0);
    rx_clk_en = 1'b1;

    // pop lands on the push clock while empty
    fork
      frame(0, 8'h77, 8, 2'b00, 0, 1, 1, 0, -1);
      begin
        idle(156);
        chk("pre_push_empty", empty, 1);
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
        chk("push_empty_fall", empty, 0);
      end
    join
    idle(32);
    chk("coinc_empty_cnt", count, 1);
    chk("coinc_empty_data", rd_data, 8'h77);
    pop();

    // break: two frame times low
    rx = 1'b0;
    idle(320);
    chk("brk_held_empty", empty, 1);
    rx = 1'b1;
    idle(40);
    chk("brk_det", break_det, 1);
    chk("brk_no_push", empty, 1);
    frame(0, 8'h5A, 8, 2'b00, 0, 1, 1, 0, -1);
    idle(32);
    chk("after_brk_data", rd_data, 8'h5A);
    chk("after_brk_cnt", count, 1);
    pop();
    state_clear = 1'b1;
    idle(1);
    state_clear = 1'b0;
    chk("brk_cleared", break_det, 0);

    // 7 data bits, two stop bits, x8 oversampling
    two_stop = 1'b1;
    frame(1, 8'h7F, 7, 2'b00, 0, 1, 0, 1, -1);
    idle(24);
    chk("b_data", b_rd_data, 7'h7F);
    chk("b_ferr", b_rd_ferr, 1);
    chk("b_count", b_count, 1);
    b_rx = 1'b0;
    idle(8);
    b_rx = 1'b1;
    idle(12);
    b_rst = 1'b0;
    #1;
    chk("b_mid_rst_empty", b_empty, 1);
    chk("b_mid_rst_count", b_count, 0);
    idle(3);
    b_rst = 1'b1;
    idle(40);
    chk("b_no_partial", b_empty, 1);
    frame(1, 8'h2A, 7, 2'b00, 0, 1, 1, 1, -1);
    idle(24);
    chk("b2_data", b_rd_data, 7'h2A);
    chk("b2_ferr", b_rd_ferr, 0);
    chk("b2_perr", b_rd_perr, 0);
    chk("b2_count", b_count, 1);
    two_stop = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
